// File: rtl/serial_alu_seq_if.sv
// Bus between the bit-serial ALU/sequencer and its surroundings: the
// controller side (start, alu_op), the register file side (operand bits in,
// shift/store strobes and result word out) and the status flags.
interface serial_alu_seq_if #(
    parameter int REG_WIDTH = 8
);
    logic                 start;
    logic [2:0]           alu_op;
    logic                 rs1_bit;
    logic                 rs2_bit;
    logic                 reg_shift_en;
    logic                 reg_store_en;
    logic [REG_WIDTH-1:0] acc;
    logic                 carry_out;
    logic                 zero;
    logic                 busy;
    logic                 done;

    // Controller / register file side: issues operations and supplies bits.
    modport master (
        output start, alu_op, rs1_bit, rs2_bit,
        input  reg_shift_en, reg_store_en, acc, carry_out, zero, busy, done
    );

    // ALU side: consumes operand bits, drives strobes, result and flags.
    modport slave (
        input  start, alu_op, rs1_bit, rs2_bit,
        output reg_shift_en, reg_store_en, acc, carry_out, zero, busy, done
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU and sequencer. Consumes one operand bit pair per cycle for
// REG_WIDTH cycles, builds the result LSB-first in acc, then strobes a
// one-cycle parallel store back into the register file. All strobes and
// flags are flops so they never depend combinationally on start.
module serial_alu_seq #(
    parameter int REG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_alu_seq_if.slave  bus
);
    localparam int CW = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(REG_WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLLI = 3'b101;
    localparam logic [2:0] OP_SRLI = 3'b110;
    localparam logic [2:0] OP_MOV  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        STORE = 2'b10
    } state_t;

    state_t               state;
    logic [2:0]           op_q;
    logic [REG_WIDTH-1:0] acc_q;
    logic [CW-1:0]        cnt;
    logic                 carry_q;
    logic                 carry_out_q;
    logic                 zero_q;
    logic                 shift_en_q;
    logic                 store_en_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 b_eff;
    logic                 arith;
    logic                 sum_bit;
    logic                 maj;
    logic                 res_bit;
    logic [REG_WIDTH-1:0] acc_next;

    // One-bit datapath: SUB inverts B and relies on the carry starting at 1.
    always_comb begin
        b_eff   = bus.rs2_bit ^ (op_q == OP_SUB);
        arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
        sum_bit = bus.rs1_bit ^ b_eff ^ carry_q;
        maj     = (bus.rs1_bit & b_eff) | (bus.rs1_bit & carry_q) | (b_eff & carry_q);
        res_bit = bus.rs1_bit;
        case (op_q)
            OP_ADD, OP_SUB:   res_bit = sum_bit;
            OP_AND:           res_bit = bus.rs1_bit & bus.rs2_bit;
            OP_OR:            res_bit = bus.rs1_bit | bus.rs2_bit;
            OP_XOR:           res_bit = bus.rs1_bit ^ bus.rs2_bit;
            OP_SLLI, OP_SRLI: res_bit = bus.rs1_bit;
            OP_MOV:           res_bit = bus.rs2_bit;
            default:          res_bit = bus.rs1_bit;
        endcase
        acc_next = {res_bit, acc_q[REG_WIDTH-1:1]};
    end

    // Sequencer: IDLE -> SHIFT (REG_WIDTH cycles) -> STORE (one cycle) -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            cnt         <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            store_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q        <= bus.alu_op;
                        acc_q       <= '0;
                        cnt         <= '0;
                        carry_q     <= (bus.alu_op == OP_SUB);
                        carry_out_q <= 1'b0;
                        zero_q      <= 1'b0;
                        shift_en_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q   <= acc_next;
                    cnt     <= cnt + 1'b1;
                    carry_q <= arith ? maj : 1'b0;
                    if (cnt == LAST_BIT) begin
                        carry_out_q <= arith ? maj : 1'b0;
                        zero_q      <= (acc_next == '0);
                        shift_en_q  <= 1'b0;
                        store_en_q  <= 1'b1;
                        done_q      <= 1'b1;
                        state       <= STORE;
                    end
                end
                STORE: begin
                    store_en_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    shift_en_q <= 1'b0;
                    store_en_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.reg_shift_en = shift_en_q;
    assign bus.reg_store_en = store_en_q;
    assign bus.acc          = acc_q;
    assign bus.carry_out    = carry_out_q;
    assign bus.zero         = zero_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial ALU and sequencer that sits directly downstream of the serial register file. It consumes one operand bit pair per cycle (`rs1_bit`, `rs2_bit`) and drives the file's `reg_shift_en` for exactly REG_WIDTH cycles. It assembles the result LSB-first in an internal accumulator, then issues a one-cycle `reg_store_en` so the file writes `acc` back in parallel. It also reports carry and zero flags and a `done` strobe to the instruction controller.

## Interface
Parameters:
- `REG_WIDTH`, 8: operand/result width; sets the shift-phase length.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin an operation; sampled only in IDLE.
- `alu_op` in 3: operation, captured at the accepted `start`.
- `rs1_bit` in 1: operand A bit for the current bit position (shift already applied upstream for SLLI/SRLI).
- `rs2_bit` in 1: operand B bit for the current bit position.
- `reg_shift_en` out 1: high throughout the SHIFT phase; advances the register file bit index.
- `reg_store_en` out 1: one-cycle parallel write strobe to the register file.
- `acc` out REG_WIDTH: result word; feeds `regs_parallel_in`.
- `carry_out` out 1: final carry of ADD/SUB (1 = no borrow for SUB); 0 for other ops.
- `zero` out 1: `acc == 0` after completion.
- `busy` out 1: state != IDLE.
- `done` out 1: high during the STORE cycle.

## Operation
- States:
  - IDLE: outputs idle; `start`=1 captures `alu_op` into `op_q`, clears `acc`, clears `cnt`, and initialises carry: 1 if op=SUB, else 0. Next state is SHIFT.
  - SHIFT: `reg_shift_en`=1. Each cycle computes `res_bit` from `rs1_bit`, `rs2_bit` and the carry flop, sets `acc <= {res_bit, acc[REG_WIDTH-1:1]}`, and increments `cnt`. After the cycle with `cnt == REG_WIDTH-1`, next state is STORE.
  - STORE: `reg_store_en`=1, `done`=1, `acc` holds the full result. `carry_out` and `zero` were registered at the last SHIFT edge. Next state is IDLE.
- `op_q` encoding (A=`rs1_bit`, B=`rs2_bit`, c=carry flop):
  - 000 ADD: `res_bit` = A^B^c; c <= majority(A,B,c).
  - 001 SUB: B is inverted, then as ADD (c starts at 1).
  - 010 AND; 011 OR; 100 XOR.
  - 101 SLLI and 110 SRLI: `res_bit` = A (shift performed upstream).
  - 111 MOV: `res_bit` = B.
  - Logic, shift and MOV ops leave c at 0.
- `carry_out` is loaded with the final c after bit REG_WIDTH-1, and forced to 0 for non-arithmetic ops.
- `zero` is computed from the final `acc` value and loaded on the same edge as `carry_out`.
- `carry_out` and `zero` hold until the next accepted `start`, which clears both.
- `start` while `busy` is ignored; there is no queuing.
- `alu_op` changes after capture do not affect the current operation. The controller must still hold `alu_op` stable for the register file's shift muxing.

## Timing
- Reset values: state=IDLE; `acc`, `cnt`, carry, `op_q`, `carry_out`, `zero` = 0; all strobes 0. Reset is asynchronous, so outputs go low without waiting for a clock edge.
- Latency for `start` sampled at edge E:
  - SHIFT occupies cycles E+1 through E+REG_WIDTH.
  - STORE is cycle E+REG_WIDTH+1.
  - IDLE resumes at E+REG_WIDTH+2.
  - The earliest next `start` is sampled at the end of that IDLE cycle (10-cycle throughput with REG_WIDTH=8).
- `reg_shift_en`, `reg_store_en`, `done` and `busy` are decoded from registered state only; they are glitch-free and independent of `start`.
- Bit alignment: the regfile bit index equals `cnt` during every SHIFT cycle. REG_WIDTH increments wrap a log2(REG_WIDTH)-bit index back to its starting value.
- `reg_shift_en` and `reg_store_en` are never high together.
- Reset mid-operation aborts immediately: no store strobe is issued, and a partial `acc` is discarded (reset to 0). `rst` must be shared with the register file so its bit index realigns.

## Test plan
- ADD 0x5A + 0x3C (bits driven by a model indexed on `cnt`) -> `reg_store_en` at cycle 9 after `start`, `acc`=0x96, `carry_out`=0, `zero`=0; `reg_shift_en` high for exactly 8 cycles.
- ADD 0xFF + 0x01 -> `acc`=0x00, `carry_out`=1, `zero`=1. SUB 0x10 - 0x01 -> `acc`=0x0F, `carry_out`=1.
- SUB 0x00 - 0x01 -> `acc`=0xFF, `carry_out`=0. XOR 0xF0 ^ 0x3C -> 0xCC; AND -> 0x30; OR -> 0xFC; MOV B=0xA5 -> 0xA5, `carry_out`=0.
- `start` held high continuously -> operations accepted only from IDLE, one every 10 cycles. `alu_op` toggled mid-SHIFT -> result follows the captured op.
- Assert `rst` asynchronously during SHIFT cycle 4 -> `busy`, `reg_shift_en`, `acc` = 0 before the next edge; no `reg_store_en`. The next `start` completes correctly.
